// File: rtl/ring_freq_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
// Free-running window mode is selected with RING_FREQ_CONTINUOUS_EN.
package ring_freq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        GATE,
        DONE
    } state_t;

    localparam logic [2:0] TAP_DIV2   = 3'd0;
    localparam logic [2:0] TAP_DIV4   = 3'd1;
    localparam logic [2:0] TAP_DIV8   = 3'd2;
    localparam logic [2:0] TAP_DIV16  = 3'd3;
    localparam logic [2:0] TAP_DIV32  = 3'd4;
    localparam logic [2:0] TAP_DIV64  = 3'd5;
    localparam logic [2:0] TAP_DIV128 = 3'd6;
    localparam logic [2:0] MAX_SEL    = TAP_DIV128;

    localparam int DEF_SYNC_STAGES = 2;

    function automatic logic [2:0] sel_clamp(input logic [2:0] s);
        return (s > MAX_SEL) ? MAX_SEL : s;
    endfunction

endpackage

// File: rtl/ring_tap_sync.sv
// Multi-flop synchroniser bringing one divided ring tap into clk.
// Async active-low reset clears the whole chain.
module ring_tap_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/ring_freq_meter.sv
// Gated edge counter for a selected ring-divider tap.
// RING_FREQ_CONTINUOUS_EN: self-starting back-to-back windows.
module ring_freq_meter
    import ring_freq_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int GATE_W      = 16,
    parameter int GATE_CYCLES = 1000,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       clk_div_i,
    input  logic [2:0]       sel_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

`ifdef RING_FREQ_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    state_t            state;
    state_t            next_state;
    logic [2:0]        sel_q;
    logic [2:0]        sel_new;
    logic [GATE_W-1:0] win_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic              ovf_flag;
    logic              tap;
    logic              sync_out;
    logic              sync_prev;
    logic              edge_det;
    logic              go;
    logic              resel;
    logic              settle_end;
    logic              gate_end;
    logic              load_sel;
    logic              publish;
    logic              clr_cnt;

    assign sel_new    = sel_clamp(sel_i);
    assign go         = CONT | start_i;
    assign resel      = sel_new != sel_q;
    assign settle_end = win_cnt == GATE_W'(SYNC_STAGES);
    assign gate_end   = win_cnt == GATE_W'(GATE_CYCLES - 1);
    assign tap        = clk_div_i[sel_q];
    assign edge_det   = sync_out & ~sync_prev;

    ring_tap_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (tap),
        .q    (sync_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:   if (go) next_state = SETTLE;
            SETTLE: if (settle_end) next_state = GATE;
            GATE:   if (gate_end) next_state = DONE;
            DONE: begin
                if (!CONT)      next_state = IDLE;
                else if (resel) next_state = SETTLE;
                else            next_state = GATE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load_sel = 1'b0;
        publish  = 1'b0;
        clr_cnt  = 1'b0;
        unique case (1'b1)
            state == IDLE: load_sel = go;
            state == DONE: begin
                publish  = 1'b1;
                clr_cnt  = 1'b1;
                load_sel = CONT;
            end
            default: ;
        endcase
    end

    // One counter times both the synchroniser flush and the gate window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
        end else if (state == SETTLE) begin
            win_cnt <= settle_end ? '0 : win_cnt + 1'b1;
        end else if (state == GATE) begin
            win_cnt <= gate_end ? '0 : win_cnt + 1'b1;
        end else begin
            win_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_prev <= sync_out;
            if (load_sel) sel_q <= sel_new;
        end
    end

    // Saturate rather than wrap; the flag marks an edge that was lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
        end else if (clr_cnt) begin
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
        end else if (state == GATE && edge_det) begin
            if (&edge_cnt) ovf_flag <= 1'b1;
            else           edge_cnt <= edge_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            count_o <= '0;
            ovf_o   <= 1'b0;
        end else begin
            done_o <= publish;
            if (state == IDLE && go) busy_o <= 1'b1;
            else if (publish)        busy_o <= CONT;
            if (publish) begin
                count_o <= edge_cnt;
                ovf_o   <= ovf_flag;
            end
        end
    end

endmodule

// File: tb/tb_ring_freq_meter.sv
// Directed bench for ring_freq_meter (GATE_CYCLES=100, SYNC_STAGES=2).
// Second instance with CNT_W=4 exercises saturation.
module tb_ring_freq_meter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] clk_div = '0;
    logic [2:0] sel_i = '0;
    logic       start_i = 1'b0;

    logic       busy_m, done_m, ovf_m;
    logic [7:0] count_m;
    logic       busy_s, done_s, ovf_s;
    logic [3:0] count_s;

    int n_cmp = 0;
    int n_bad = 0;
    int half_ns [7] = '{50, 100, 200, 100, 400, 800, 125};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 7; g++) begin : g_div
        initial begin
            #3;
            forever begin
                #(half_ns[g]);
                clk_div[g] = ~clk_div[g];
            end
        end
    end

    ring_freq_meter #(
        .CNT_W(8), .GATE_W(16), .GATE_CYCLES(100), .SYNC_STAGES(2)
    ) u_main (
        .clk(clk), .rst_n(rst_n), .clk_div_i(clk_div), .sel_i(sel_i),
        .start_i(start_i), .busy_o(busy_m), .done_o(done_m),
        .count_o(count_m), .ovf_o(ovf_m)
    );

    ring_freq_meter #(
        .CNT_W(4), .GATE_W(16), .GATE_CYCLES(100), .SYNC_STAGES(2)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .clk_div_i(clk_div), .sel_i(sel_i),
        .start_i(start_i), .busy_o(busy_s), .done_o(done_s),
        .count_o(count_s), .ovf_o(ovf_s)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done_m && n < 400);
    endtask

    task automatic kick(input logic [2:0] sel);
        @(negedge clk);
        sel_i   = sel;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check_eq("busy_after_start", busy_m, 1);
    endtask

    task automatic measure(input string tag, input logic [2:0] sel,
                           input int exp_cnt);
        int lat;
        kick(sel);
        wait_done(lat);
        check_eq({tag, "_latency"}, lat, 104);
        check_eq({tag, "_count"}, count_m, exp_cnt);
        check_eq({tag, "_ovf"}, ovf_m, 0);
        check_eq({tag, "_busy_at_done"}, busy_m, 0);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_1cyc"}, done_m, 0);
    endtask

    initial begin
        int lat;
        int dones;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_count", count_m, 0);
        check_eq("rst_busy", busy_m, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef RING_FREQ_CONTINUOUS_EN
        start_i = 1'b0;
        @(posedge clk);
        #1;
        check_eq("cont_busy_selfstart", busy_m, 1);
        wait_done(lat);
        check_eq("cont_first_done", lat < 400, 1);
        for (int w = 0; w < 3; w++) begin
            wait_done(lat);
            check_eq("cont_period", lat, 101);
            check_eq("cont_count", count_m, 10);
            check_eq("cont_busy", busy_m, 1);
        end
        sel_i = 3'd3;
        wait_done(lat);
        check_eq("cont_period_old_sel", lat, 101);
        check_eq("cont_count_old_sel", count_m, 10);
        wait_done(lat);
        check_eq("cont_period_resettle", lat, 104);
        check_eq("cont_count_sel3", count_m, 5);
`else
        // Idle after reset with no start request.
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done_m || busy_m || ovf_m || count_m != 0) dones++;
        end
        check_eq("idle_quiet_cycles", dones, 0);
        check_eq("idle_count", count_m, 0);

        measure("basic", 3'd0, 10);
        check_eq("basic_sat_inst", count_s, 10);

        measure("sel3", 3'd3, 5);
        measure("sel7", 3'd7, 4);

        // Saturation: 25 edges per window on bit0.
        half_ns[0] = 20;
        repeat (30) @(posedge clk);
        kick(3'd0);
        wait_done(lat);
        check_eq("sat_latency", lat, 104);
        check_eq("sat_count_w4", count_s, 15);
        check_eq("sat_ovf_w4", ovf_s, 1);
        check_eq("sat_count_w8", count_m, 25);
        check_eq("sat_ovf_w8", ovf_m, 0);
        half_ns[0] = 50;
        repeat (30) @(posedge clk);
        kick(3'd0);
        wait_done(lat);
        check_eq("unsat_count_w4", count_s, 10);
        check_eq("unsat_ovf_w4", ovf_s, 0);

        // start held high, sel toggled while busy.
        @(negedge clk);
        sel_i   = 3'd0;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        dones = 0;
        for (int i = 1; i <= 104; i++) begin
            @(posedge clk);
            #1;
            if (done_m) dones++;
            if (i > 10 && i < 100) sel_i = i[0] ? 3'd1 : 3'd0;
        end
        sel_i = 3'd0;
        check_eq("busy_single_done", dones, 1);
        check_eq("busy_latched_count", count_m, 10);
        @(posedge clk);
        #1;
        check_eq("busy_restart", busy_m, 1);
        start_i = 1'b0;
        wait_done(lat);
        check_eq("busy_second_latency", lat, 104);
        check_eq("busy_second_count", count_m, 10);

        // Reset at GATE cycle 50 abandons the window.
        kick(3'd0);
        repeat (52) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_count", count_m, 0);
        check_eq("midrst_busy", busy_m, 0);
        check_eq("midrst_done", done_m, 0);
        check_eq("midrst_ovf", ovf_m, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1;
            if (done_m || busy_m) dones++;
        end
        check_eq("midrst_no_done", dones, 0);
        measure("restart", 3'd0, 10);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
